axi_slave_mem: RTL

//  AXI4 memory-backed responder: the slave end of the master interface used by the UVM env.

---
 rtl/axi_pkg.sv | 33 +++
 rtl/axi_burst_addr.sv | 64 ++++++
 rtl/axi_slave_mem.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_pkg
//  Purpose  : Shared AXI4 types and response codes for the memory-backed
//             slave: burst encoding, response constants, FSM state enums.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

endpackage
`default_nettype wire

// File: rtl/axi_burst_addr.sv
`default_nettype none
// ============================================================================
//  Module   : axi_burst_addr
//  Purpose  : Combinational beat-address helper. From the current beat
//             address and the burst attributes it produces the next beat
//             address, the memory word index of the current beat and a
//             per-beat error flag.
//  Ports    : addr      in  current beat byte address
//             len       in  beats-1
//             size      in  log2 bytes/beat
//             burst     in  burst type
//             next_addr out address of the following beat
//             idx       out word index of the current beat
//             err       out current beat must be answered with SLVERR
//  Revision : 1.0 - initial release
// ============================================================================
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int DATA_LEN  = 32,
  parameter int MEM_DEPTH = 256,
  parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic [31:0]      addr,
  input  logic [7:0]       len,
  input  logic [2:0]       size,
  input  logic [1:0]       burst,
  output logic [31:0]      next_addr,
  output logic [IDX_W-1:0] idx,
  output logic             err
);

  localparam int          BYTES     = DATA_LEN / 8;
  localparam int          ADDR_LSB  = $clog2(BYTES);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH) * 33'(BYTES);

  logic [31:0] incr_addr;
  logic [31:0] wrap_mask;
  logic        wrap_len_ok;

  always_comb begin
    incr_addr   = addr + 32'(BYTES);
    // Wrap container is (len+1) beats; its byte size is a power of two
    // whenever len is legal, so size-1 is a clean offset mask.
    wrap_mask   = ((32'(len) + 32'd1) * 32'(BYTES)) - 32'd1;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);

    case (burst)
      BURST_INCR: next_addr = incr_addr;
      BURST_WRAP: next_addr = wrap_len_ok ? ((addr & ~wrap_mask) | (incr_addr & wrap_mask))
                                          : incr_addr;
      default:    next_addr = addr;
    endcase

    err = ({1'b0, addr} >= MEM_BYTES)
       || (size != 3'(ADDR_LSB))
       || (burst == BURST_RSVD)
       || ((burst == BURST_WRAP) && !wrap_len_ok);

    idx = addr[ADDR_LSB +: IDX_W];
  end

endmodule
`default_nettype wire

// File: rtl/axi_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module   : axi_slave_mem
//  Purpose  : AXI4 memory-backed slave. Independent write (AW/W/B) and read
//             (AR/R) engines, one outstanding burst each, serving bursts from
//             an internal word array. Memory contents are not reset.
//  Ports    : ACLK/ARESET      clock, asynchronous active-high reset
//             AW* / W* / B*    write address, data and response channels
//             AR* / R*         read address and data channels
//  Revision : 1.0 - initial release
// ============================================================================
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int NUM_ID    = 4,
  parameter int DATA_LEN  = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  // write address
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [31:0]             AWADDR,
  input  logic [NUM_ID-1:0]       AWID,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  // write data
  input  logic                    WVALID,
  output logic                    WREADY,
  input  logic [DATA_LEN-1:0]     WDATA,
  input  logic [DATA_LEN/8-1:0]   WSTRB,
  input  logic                    WLAST,
  // write response
  output logic                    BVALID,
  input  logic                    BREADY,
  output logic [NUM_ID-1:0]       BID,
  output logic [1:0]              BRESP,
  // read address
  input  logic                    ARVALID,
  output logic                    ARREADY,
  input  logic [31:0]             ARADDR,
  input  logic [NUM_ID-1:0]       ARID,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  // read data
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic [DATA_LEN-1:0]     RDATA,
  output logic [NUM_ID-1:0]       RID,
  output logic [1:0]              RRESP,
  output logic                    RLAST
);

  localparam int STRB_W = DATA_LEN / 8;
  localparam int IDX_W  = $clog2(MEM_DEPTH);

  logic [DATA_LEN-1:0] mem [MEM_DEPTH];

  // ---------------------------------------------------------------- write
  wstate_t          w_state;
  logic [31:0]      w_addr;
  logic [NUM_ID-1:0] w_id;
  logic [7:0]       w_len;
  logic [2:0]       w_size;
  logic [1:0]       w_burst;
  logic [7:0]       w_cnt;
  logic             w_err;

  logic [31:0]      w_next;
  logic [IDX_W-1:0] w_idx;
  logic             w_beat_err;
  logic             w_beat;

  axi_burst_addr #(.DATA_LEN(DATA_LEN), .MEM_DEPTH(MEM_DEPTH), .IDX_W(IDX_W)) u_waddr (
    .addr      (w_addr),
    .len       (w_len),
    .size      (w_size),
    .burst     (w_burst),
    .next_addr (w_next),
    .idx       (w_idx),
    .err       (w_beat_err)
  );

  // WREADY is only high in W_DATA, so this is the accepted-beat strobe.
  assign w_beat = WVALID && WREADY;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b1;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= RESP_OKAY;
      w_addr  <= '0;
      w_id    <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (AWVALID) begin
            w_addr  <= AWADDR;
            w_id    <= AWID;
            w_len   <= AWLEN;
            w_size  <= AWSIZE;
            w_burst <= AWBURST;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            AWREADY <= 1'b0;
            WREADY  <= 1'b1;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (WVALID) begin
            w_addr <= w_next;
            w_cnt  <= w_cnt + 8'd1;
            // Burst length comes from AWLEN; WLAST only contributes an error.
            if (w_cnt == w_len) begin
              WREADY  <= 1'b0;
              BVALID  <= 1'b1;
              BID     <= w_id;
              BRESP   <= (w_err || w_beat_err || !WLAST) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end else begin
              w_err <= w_err || w_beat_err || WLAST;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Storage has no reset; errored beats leave it untouched.
  always_ff @(posedge ACLK) begin
    if (w_beat && !w_beat_err) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) mem[w_idx][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read
  rstate_t          r_state;
  logic [31:0]      r_addr;
  logic [7:0]       r_len;
  logic [2:0]       r_size;
  logic [1:0]       r_burst;
  logic [7:0]       r_cnt;

  logic [31:0]      r_cur_addr;
  logic [7:0]       r_cur_len;
  logic [2:0]       r_cur_size;
  logic [1:0]       r_cur_burst;
  logic [31:0]      r_next;
  logic [IDX_W-1:0] r_idx;
  logic             r_beat_err;

  // In idle the helper looks at the AR request so the first beat can be
  // loaded on the handshake edge; afterwards it follows the latched burst.
  always_comb begin
    if (r_state == R_IDLE) begin
      r_cur_addr  = ARADDR;
      r_cur_len   = ARLEN;
      r_cur_size  = ARSIZE;
      r_cur_burst = ARBURST;
    end else begin
      r_cur_addr  = r_addr;
      r_cur_len   = r_len;
      r_cur_size  = r_size;
      r_cur_burst = r_burst;
    end
  end

  axi_burst_addr #(.DATA_LEN(DATA_LEN), .MEM_DEPTH(MEM_DEPTH), .IDX_W(IDX_W)) u_raddr (
    .addr      (r_cur_addr),
    .len       (r_cur_len),
    .size      (r_cur_size),
    .burst     (r_cur_burst),
    .next_addr (r_next),
    .idx       (r_idx),
    .err       (r_beat_err)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b1;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RID     <= '0;
      RRESP   <= RESP_OKAY;
      RLAST   <= 1'b0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ARVALID) begin
            r_addr  <= r_next;
            r_len   <= ARLEN;
            r_size  <= ARSIZE;
            r_burst <= ARBURST;
            r_cnt   <= '0;
            RID     <= ARID;
            RVALID  <= 1'b1;
            RLAST   <= (ARLEN == 8'd0);
            RDATA   <= r_beat_err ? '0 : mem[r_idx];
            RRESP   <= r_beat_err ? RESP_SLVERR : RESP_OKAY;
            ARREADY <= 1'b0;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            if (RLAST) begin
              RVALID  <= 1'b0;
              RLAST   <= 1'b0;
              ARREADY <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_addr <= r_next;
              r_cnt  <= r_cnt + 8'd1;
              RLAST  <= ((r_cnt + 8'd1) == r_len);
              RDATA  <= r_beat_err ? '0 : mem[r_idx];
              RRESP  <= r_beat_err ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
